fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, defaults and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_BURST  = 8;

  // Width of a requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotating-priority one-hot picker
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PTR_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot
);

  logic [2*NUM_REQ-1:0] rot_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   rot_oh;
  logic [2*NUM_REQ-1:0] back_dbl;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_dbl  = {req, req} >> rr_ptr;
    rot      = rot_dbl[NUM_REQ-1:0];
    rot_oh   = rot & (~rot + {{(NUM_REQ-1){1'b0}}, 1'b1});
    back_dbl = {rot_oh, rot_oh} << rr_ptr;
    onehot   = back_dbl[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter in front of an async FIFO write port
// Burst mode (owner-locked multi-beat grants) is compiled in with FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [id_width(NUM_REQ)-1:0]    grant_id,
  output logic [31:0]                     xfer_cnt
);

  localparam int unsigned IDW = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 2 || MAX_BURST > 255) begin : g_param_out_of_range
  end

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] k);
    return (k == IDW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]        xfer_cnt_q, xfer_cnt_d;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] cand;
  logic               xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (IDW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .onehot (pick)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam logic [7:0] MAX_BEATS = 8'(MAX_BURST);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] owner_oh;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    cand              = (state_q == BURST) ? (req & owner_oh) : pick;
  end
`else
  always_comb begin
    cand = pick;
  end
`endif

  always_comb begin
    gnt          = (wr_rst || fifo_full) ? '0 : cand;
    xfer         = |(req & gnt);
    fifo_wr_en   = xfer;
    fifo_wr_data = '0;
    grant_id     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (gnt[k]) begin
        fifo_wr_data = fifo_wr_data | req_data[k*DATA_WIDTH +: DATA_WIDTH];
        grant_id     = grant_id | IDW'(k);
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q + 32'(xfer);
`ifdef FIFO_ARB_BURST_EN
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = BURST;
          owner_d    = grant_id;
          beat_cnt_d = 8'd1;
          rr_ptr_d   = next_idx(grant_id);
        end
      end
      BURST: begin
        // A dropped owner request ends the burst even while the FIFO is full.
        if (!req[owner_q]) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = next_idx(owner_q);
        end else if (xfer) begin
          if (beat_cnt_q + 8'd1 == MAX_BEATS) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = next_idx(owner_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`else
    if (xfer) begin
      rr_ptr_d = next_idx(grant_id);
    end
`endif
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
`ifdef FIFO_ARB_BURST_EN
      state_q    <= IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
`ifdef FIFO_ARB_BURST_EN
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench for fifo_wr_arbiter with a depth-16 FIFO model
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int MB    = 4;
  localparam int DEPTH = 16;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic            wr_clk = 1'b0;
  logic            wr_rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic [31:0]     xfer_cnt;

  int checks = 0;
  int errors = 0;

  int          m_ptr, m_owner, m_beats;
  bit          m_burst;
  logic [31:0] m_cnt;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] dq[$];
  int            grant_log[$];
  bit            force_full;
  bit            do_pop;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .xfer_cnt     (xfer_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = 0;
    m_beats = 0;
    m_burst = 1'b0;
    m_cnt   = '0;
  endtask

  function automatic int model_pick();
    if (wr_rst || fifo_full) return -1;
    if (m_burst) return req[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (wr_rst) begin
      model_reset();
      return;
    end
    if (g >= 0) m_cnt = m_cnt + 1;
    if (m_burst) begin
      if (!req[m_owner]) begin
        m_burst = 1'b0;
        m_ptr   = (m_owner + 1) % N;
      end else if (g >= 0) begin
        m_beats++;
        if (m_beats == MB) begin
          m_burst = 1'b0;
          m_ptr   = (m_owner + 1) % N;
        end
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (BURST_EN) begin
        m_burst = 1'b1;
        m_owner = g;
        m_beats = 1;
      end
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = $urandom;
  endtask

  task automatic pop_cmp(input string tag);
    logic [DW-1:0] a, b;
    chk({tag, ".dq_size"}, 64'(dq.size()), 64'(mq.size()));
    if (dq.size() > 0 && mq.size() > 0) begin
      a = dq.pop_front();
      b = mq.pop_front();
      chk({tag, ".rd_data"}, 64'(a), 64'(b));
    end
  endtask

  // One cycle: inputs already set at the falling edge, check outputs, then clock.
  task automatic step(input string tag);
    int            g;
    logic [DW-1:0] ed;
    bit            dw;
    logic [DW-1:0] dd;
    fifo_full = force_full || (mq.size() >= DEPTH);
    #1;
    g  = model_pick();
    ed = (g < 0) ? '0 : req_data[g*DW +: DW];
    chk({tag, ".gnt"}, 64'(gnt), (g < 0) ? 64'd0 : (64'd1 << g));
    chk({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(g >= 0));
    chk({tag, ".wr_data"}, 64'(fifo_wr_data), 64'(ed));
    chk({tag, ".grant_id"}, 64'(grant_id), (g < 0) ? 64'd0 : 64'(g));
    chk({tag, ".xfer_cnt"}, 64'(xfer_cnt), 64'(m_cnt));
    dw = fifo_wr_en;
    dd = fifo_wr_data;
    @(posedge wr_clk);
    if (dw) dq.push_back(dd);
    if (g >= 0) begin
      mq.push_back(ed);
      grant_log.push_back(g);
    end
    model_update(g);
    if (do_pop && mq.size() > 0) pop_cmp(tag);
    @(negedge wr_clk);
  endtask

  task automatic drain(input string tag);
    req    = '0;
    do_pop = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 8 && mq.size() > 0; i++) step(tag);
    chk({tag, ".drained"}, 64'(dq.size()), 64'(mq.size()));
    do_pop = 1'b0;
  endtask

  initial begin
    int exp2[3];
    wr_rst     = 1'b1;
    req        = '0;
    req_data   = '0;
    force_full = 1'b0;
    do_pop     = 1'b0;
    fifo_full  = 1'b0;
    model_reset();
    repeat (2) @(negedge wr_clk);

    // Outputs stay quiet under reset even with every requester asking.
    req = '1;
    rand_data();
    step("rst");
    wr_rst = 1'b0;

    // All four requesting: single-beat rotation, or four-beat bursts when compiled in.
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step("all4");
    end
    chk("all4.cnt", 64'(xfer_cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("all4.order", 64'(grant_log[i]), BURST_EN ? 64'(i / 4) : 64'(i % 4));
    end
    drain("d1");

    // Forced full stall, then grants resume.
    req        = 4'b1010;
    force_full = 1'b1;
    repeat (3) begin
      rand_data();
      step("stall");
    end
    force_full = 1'b0;
    grant_log.delete();
    repeat (3) begin
      rand_data();
      step("1010");
    end
    if (BURST_EN) exp2 = '{3, 3, 3};
    else exp2 = '{1, 3, 1};
    for (int i = 0; i < 3; i++) chk("1010.order", 64'(grant_log[i]), 64'(exp2[i]));
    drain("d2");

    // Requester 2 drops after two beats; requester 3 is next.
    req = 4'b0100;
    repeat (2) begin
      rand_data();
      step("drop");
    end
    req = 4'b1000;
    repeat (2) begin
      rand_data();
      step("drop3");
    end
    drain("d3");

    // Reset mid-burst, then restart from requester 0.
    req = '1;
    repeat (2) begin
      rand_data();
      step("pre_rst");
    end
    wr_rst = 1'b1;
    model_reset();
    step("mid_rst");
    wr_rst = 1'b0;
    grant_log.delete();
    rand_data();
    step("post_rst");
    chk("post_rst.first", 64'(grant_log[0]), 64'd0);
    drain("d4");

    // Randomized traffic with full stalls, reads and occasional resets.
    for (int i = 0; i < 400; i++) begin
      req        = N'($urandom);
      force_full = ($urandom_range(7) == 0);
      do_pop     = ($urandom_range(2) != 0);
      rand_data();
      if ($urandom_range(99) == 0) begin
        wr_rst = 1'b1;
        model_reset();
        step("rnd_rst");
        wr_rst = 1'b0;
      end else begin
        step("rnd");
      end
    end
    force_full = 1'b0;
    drain("d5");

    // Fill an empty FIFO with no reads: exactly DEPTH writes land.
    req = '1;
    for (int i = 0; i < DEPTH + 8; i++) begin
      rand_data();
      step("fill");
    end
    chk("fill.count", 64'(dq.size()), 64'(DEPTH));
    drain("d6");
    chk("final.size", 64'(dq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
